// File: rtl/alu_acc_ctrl.sv
// Accumulator sequencer for an external ALU: FIFO-buffered commands, one retires every 2 cycles,
// done 2 edges after acceptance when idle; cmd_ready falls while the FIFO holds DEPTH entries.
module alu_acc_ctrl #(
  parameter int width = 6,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [2:0]       cmd_op,
  input  logic [width-1:0] cmd_data,
  output logic [width-1:0] alu_a,
  output logic [width-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [width-1:0] alu_res,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  input  logic             alu_zero,
  input  logic             alu_neg,
  output logic [width-1:0] acc,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_z,
  output logic             flag_n,
  output logic             done,
  output logic             busy
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic             load;
    logic [2:0]       op;
    logic [width-1:0] data;
  } cmd_t;

  typedef enum logic {IDLE, EXEC} state_t;

  cmd_t             mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  state_t           state_q, state_d;
  cmd_t             cr_q, cr_d;
  logic [width-1:0] acc_q, acc_d;
  logic [3:0]       flags_q, flags_d;
  logic             done_q, done_d;
  logic             push, pop;
  cmd_t             cmd_in;

  assign cmd_in    = '{load: cmd_load, op: cmd_op, data: cmd_data};
  assign cmd_ready = (count_q < CW'(DEPTH)) & rst_n;
  assign push      = cmd_valid & cmd_ready;
  // No bypass: the FSM only ever pops what is already stored.
  assign pop       = (state_q == IDLE) && (count_q != '0);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_in;
  end

  always_comb begin
    state_d  = state_q;
    cr_d     = cr_q;
    acc_d    = acc_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    case (state_q)
      IDLE: begin
        if (pop) begin
          cr_d    = mem_q[rd_ptr_q];
          state_d = EXEC;
        end
      end
      EXEC: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (cr_q.load) begin
          acc_d   = cr_q.data;
          flags_d = {1'b0, 1'b0, (cr_q.data == '0), cr_q.data[width-1]};
        end else begin
          acc_d   = alu_res;
          flags_d = {alu_carry, alu_overflow, alu_zero, alu_neg};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cr_q     <= '0;
      acc_q    <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cr_q     <= cr_d;
      acc_q    <= acc_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
    end
  end

  // ALU operands come straight from registers so they hold steady across EXEC.
  assign alu_a  = acc_q;
  assign alu_b  = cr_q.data;
  assign alu_op = cr_q.op;
  assign acc    = acc_q;
  assign flag_c = flags_q[3];
  assign flag_v = flags_q[2];
  assign flag_z = flags_q[1];
  assign flag_n = flags_q[0];
  assign done   = done_q;
  assign busy   = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_alu_acc_ctrl.sv
// Scoreboard bench for alu_acc_ctrl with a behavioural 6-bit ALU attached.
// Driver pushes hand-computed expectations on acceptance; monitor pops on each done pulse.
module tb_alu_acc_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_load;
  logic [2:0] cmd_op;
  logic [5:0] cmd_data;
  logic [5:0] alu_a, alu_b, alu_res, acc;
  logic [2:0] alu_op;
  logic       alu_carry, alu_overflow, alu_zero, alu_neg;
  logic       flag_c, flag_v, flag_z, flag_n, done, busy;
  logic [6:0] sum;

  always #5 clk = ~clk;

  alu_acc_ctrl #(.width(6), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
    .cmd_op(cmd_op), .cmd_data(cmd_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_res(alu_res), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .alu_zero(alu_zero), .alu_neg(alu_neg),
    .acc(acc), .flag_c(flag_c), .flag_v(flag_v), .flag_z(flag_z), .flag_n(flag_n),
    .done(done), .busy(busy)
  );

  // Behavioural ALU: carry on SUB is the borrow out.
  always_comb begin
    sum          = '0;
    alu_res      = '0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    case (alu_op)
      3'b000: begin
        sum          = {1'b0, alu_a} + {1'b0, alu_b};
        alu_res      = sum[5:0];
        alu_carry    = sum[6];
        alu_overflow = (alu_a[5] == alu_b[5]) && (sum[5] != alu_a[5]);
      end
      3'b001: begin
        sum          = {1'b0, alu_a} - {1'b0, alu_b};
        alu_res      = sum[5:0];
        alu_carry    = sum[6];
        alu_overflow = (alu_a[5] != alu_b[5]) && (sum[5] != alu_a[5]);
      end
      3'b010:  alu_res = alu_a & alu_b;
      3'b011:  alu_res = alu_a | alu_b;
      3'b100:  alu_res = alu_a ^ alu_b;
      default: alu_res = alu_a;
    endcase
  end
  assign alu_zero = (alu_res == 6'd0);
  assign alu_neg  = alu_res[5];

  typedef struct {
    logic [5:0] acc;
    logic [3:0] fl;
    logic [5:0] a;
    logic [5:0] b;
    logic [2:0] op;
    int         acyc;
    bit         chk_lat;
  } exp_t;

  typedef struct {
    logic       ld;
    logic [2:0] op;
    logic [5:0] d;
    logic [5:0] eacc;
    logic [3:0] efl;
  } vec_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         ndone = 0;
  int         last_done_cyc = 0;
  bit         prev_in_gap = 1'b0;
  bit         chk_gap = 1'b0;
  bit         bp_seen = 1'b0;
  logic [5:0] last_acc = '0;
  logic [5:0] prev_a = '0, prev_b = '0;
  logic [2:0] prev_op = '0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: operands sampled one cycle before done belong to the EXEC cycle.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      ndone++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done: pulse with nothing outstanding (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        check("acc", 16'(acc), 16'(e.acc));
        check("flags CVZN", 16'({flag_c, flag_v, flag_z, flag_n}), 16'(e.fl));
        check("alu_a in EXEC", 16'(prev_a), 16'(e.a));
        check("alu_b in EXEC", 16'(prev_b), 16'(e.b));
        check("alu_op in EXEC", 16'(prev_op), 16'(e.op));
        if (e.chk_lat) check("accept-to-done edges", 16'(cyc - e.acyc), 16'd2);
      end
      if (chk_gap && prev_in_gap) check("done spacing", 16'(cyc - last_done_cyc), 16'd2);
      last_done_cyc = cyc;
      prev_in_gap   = chk_gap;
    end
    if (chk_gap && cmd_valid && !cmd_ready) bp_seen = 1'b1;
    prev_a  = alu_a;
    prev_b  = alu_b;
    prev_op = alu_op;
    cyc++;
  end

  task automatic send(input logic ld, input logic [2:0] op, input logic [5:0] d,
                      input logic [5:0] eacc, input logic [3:0] efl,
                      input bit track, input bit lat);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_load  = ld;
    cmd_op    = op;
    cmd_data  = d;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL send: cmd_ready stuck low for 50 cycles (t=%0t)", $time);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (track) begin
      e.acc = eacc; e.fl = efl; e.a = last_acc; e.b = d; e.op = op;
      e.acyc = cyc; e.chk_lat = lat;
      sb.push_back(e);
      last_acc = eacc;
    end
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while ((sb.size() != 0 || busy) && n < 100);
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d results still outstanding, busy=%0b", sb.size(), busy);
    end
  endtask

  vec_t t5[10];
  int   done_before;

  initial begin
    t5 = '{
      '{1'b1, 3'b000, 6'd10, 6'd10, 4'b0000},
      '{1'b0, 3'b000, 6'd5,  6'd15, 4'b0000},
      '{1'b0, 3'b001, 6'd20, 6'd59, 4'b1001},
      '{1'b0, 3'b010, 6'd15, 6'd11, 4'b0000},
      '{1'b0, 3'b011, 6'd48, 6'd59, 4'b0001},
      '{1'b0, 3'b100, 6'd59, 6'd0,  4'b0010},
      '{1'b1, 3'b000, 6'd33, 6'd33, 4'b0001},
      '{1'b0, 3'b001, 6'd1,  6'd32, 4'b0001},
      '{1'b0, 3'b000, 6'd32, 6'd0,  4'b1110},
      '{1'b0, 3'b100, 6'd42, 6'd42, 4'b0001}
    };
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_op = '0; cmd_data = '0;
    repeat (2) @(negedge clk);
    check("cmd_ready in reset", 16'(cmd_ready), 16'd0);
    rst_n = 1'b1;
    #1;
    check("reset acc", 16'(acc), 16'd0);
    check("reset flags", 16'({flag_c, flag_v, flag_z, flag_n}), 16'd0);
    check("reset done/busy", 16'({done, busy}), 16'd0);
    check("reset alu drive", 16'({alu_a, alu_b, alu_op}), 16'd0);
    check("cmd_ready after reset", 16'(cmd_ready), 16'd1);

    send(1'b1, 3'b000, 6'd24, 6'd24, 4'b0000, 1'b1, 1'b1);
    send(1'b0, 3'b000, 6'd3,  6'd27, 4'b0000, 1'b1, 1'b0);
    drain();
    send(1'b1, 3'b000, 6'd63, 6'd63, 4'b0001, 1'b1, 1'b1);
    send(1'b0, 3'b000, 6'd1,  6'd0,  4'b1010, 1'b1, 1'b0);
    drain();
    send(1'b1, 3'b000, 6'd31, 6'd31, 4'b0000, 1'b1, 1'b1);
    send(1'b0, 3'b000, 6'd1,  6'd32, 4'b0101, 1'b1, 1'b0);
    drain();
    send(1'b1, 3'b000, 6'd0,  6'd0,  4'b0010, 1'b1, 1'b1);
    drain();

    // Continuous stream: the FIFO fills and ready must push back.
    chk_gap     = 1'b1;
    done_before = ndone;
    for (int i = 0; i < 10; i++)
      send(t5[i].ld, t5[i].op, t5[i].d, t5[i].eacc, t5[i].efl, 1'b1, i == 0);
    drain();
    chk_gap = 1'b0;
    check("stream done count", 16'(ndone - done_before), 16'd10);
    check("stream backpressure seen", 16'(bp_seen), 16'd1);

    // Reset lands on the write-back edge of the second command.
    send(1'b1, 3'b000, 6'd5, 6'd5, 4'b0000, 1'b1, 1'b1);
    send(1'b0, 3'b000, 6'd1, 6'd0, 4'b0000, 1'b0, 1'b0);
    send(1'b0, 3'b000, 6'd1, 6'd0, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("cmd_ready while rst_n low", 16'(cmd_ready), 16'd0);
    done_before = ndone;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    check("no done after mid-op reset", 16'(ndone - done_before), 16'd0);
    check("acc after mid-op reset", 16'(acc), 16'd0);
    check("flags after mid-op reset", 16'({flag_c, flag_v, flag_z, flag_n}), 16'd0);
    check("busy after mid-op reset", 16'(busy), 16'd0);
    check("cmd_ready after mid-op reset", 16'(cmd_ready), 16'd1);
    check("alu drive after mid-op reset", 16'({alu_a, alu_b, alu_op}), 16'd0);
    check("scoreboard empty", 16'(sb.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
